// File: rtl/transmissao_serial_uc.sv
// transmissao_serial_uc: control unit for the 3x3 pixel serial transmission datapath.
// Walks the pixel RAM row by row and column by column. Each 16-bit pixel is sent as two UART
// bytes: high byte first (shift_serial=0), then low byte (shift_serial=1). A one-cycle
// fim_transmissao pulse marks the end of the frame.
//
// Optional feature macro: TRANSMISSAO_SERIAL_TIMEOUT_EN
//   defined     -> per-byte pronto timeout of TIMEOUT_CICLOS cycles, ERRO state, erro flag
//   not defined -> ESPERA states wait forever, erro tied to 0
//
// Ports:
//   clock, reset          clock, synchronous active-high reset
//   transmitir            start request (sampled in INICIAL/ERRO)
//   pronto                UART end-of-frame pulse
//   fim_coluna, fim_linha last column / last row flags from the address counters
//   shift_serial          current byte-select flip-flop value
//   partida_serial        UART start pulse
//   flipa                 toggle byte-select flip-flop
//   conta_coluna/linha    increment column / row counter
//   zera_coluna/linha     clear column / row counter
//   ocupado               busy (every state except INICIAL/ERRO)
//   fim_transmissao       one-cycle done pulse
//   erro                  timeout flag
//   db_estado             current state code
module transmissao_serial_uc #(
    parameter int unsigned TIMEOUT_CICLOS = 50000,
    parameter int unsigned W_TIMEOUT      = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       transmitir,
    input  logic       pronto,
    input  logic       fim_coluna,
    input  logic       fim_linha,
    input  logic       shift_serial,
    output logic       partida_serial,
    output logic       flipa,
    output logic       conta_coluna,
    output logic       conta_linha,
    output logic       zera_coluna,
    output logic       zera_linha,
    output logic       ocupado,
    output logic       fim_transmissao,
    output logic       erro,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL      = 4'h0,
        PREPARA      = 4'h1,
        LEITURA      = 4'h2,
        ENVIA_ALTO   = 4'h3,
        ESPERA_ALTO  = 4'h4,
        TROCA_BYTE   = 4'h5,
        ENVIA_BAIXO  = 4'h6,
        ESPERA_BAIXO = 4'h7,
        TROCA_VOLTA  = 4'h8,
        PROXIMO      = 4'h9,
        CONTA_COLUNA = 4'hA,
        CONTA_LINHA  = 4'hB,
`ifdef TRANSMISSAO_SERIAL_TIMEOUT_EN
        FINAL        = 4'hC,
        ERRO         = 4'hE
`else
        FINAL        = 4'hC
`endif
    } estado_t;

    estado_t estado_q, estado_d;

    logic partida_serial_q, partida_serial_d;
    logic flipa_q, flipa_d;
    logic conta_coluna_q, conta_coluna_d;
    logic conta_linha_q, conta_linha_d;
    logic zera_coluna_q, zera_coluna_d;
    logic zera_linha_q, zera_linha_d;
    logic ocupado_q, ocupado_d;
    logic fim_transmissao_q, fim_transmissao_d;
    logic erro_q, erro_d;

`ifdef TRANSMISSAO_SERIAL_TIMEOUT_EN
    logic [W_TIMEOUT-1:0] timeout_q, timeout_d;
    logic                 timeout_c;

    assign timeout_c = (timeout_q == W_TIMEOUT'(TIMEOUT_CICLOS - 1));

    // Counter restarts on every ESPERA entry and advances only while the FSM stays there.
    always_comb begin
        timeout_d = '0;
        if ((estado_q == ESPERA_ALTO || estado_q == ESPERA_BAIXO) && estado_d == estado_q) begin
            timeout_d = timeout_q + W_TIMEOUT'(1);
        end
    end
`else
    logic unused_params;
    assign unused_params = ^{TIMEOUT_CICLOS, W_TIMEOUT};
`endif

    // Next-state logic; pronto is only looked at in the ESPERA states.
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:      if (transmitir) estado_d = PREPARA;
            PREPARA:      estado_d = LEITURA;
            LEITURA:      estado_d = ENVIA_ALTO;
            ENVIA_ALTO:   estado_d = ESPERA_ALTO;
            ESPERA_ALTO: begin
                if (pronto) estado_d = TROCA_BYTE;
`ifdef TRANSMISSAO_SERIAL_TIMEOUT_EN
                else if (timeout_c) estado_d = ERRO;
`endif
            end
            TROCA_BYTE:   estado_d = ENVIA_BAIXO;
            ENVIA_BAIXO:  estado_d = ESPERA_BAIXO;
            ESPERA_BAIXO: begin
                if (pronto) estado_d = TROCA_VOLTA;
`ifdef TRANSMISSAO_SERIAL_TIMEOUT_EN
                else if (timeout_c) estado_d = ERRO;
`endif
            end
            TROCA_VOLTA:  estado_d = PROXIMO;
            PROXIMO: begin
                if (fim_coluna && fim_linha) estado_d = FINAL;
                else if (fim_coluna)         estado_d = CONTA_LINHA;
                else                         estado_d = CONTA_COLUNA;
            end
            CONTA_COLUNA: estado_d = LEITURA;
            CONTA_LINHA:  estado_d = LEITURA;
            FINAL:        estado_d = INICIAL;
`ifdef TRANSMISSAO_SERIAL_TIMEOUT_EN
            ERRO:         if (transmitir) estado_d = PREPARA;
`endif
            default:      estado_d = INICIAL;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with estado_q.
    // In PREPARA flipa copies shift_serial to bring the byte select back to the high byte.
    always_comb begin
        partida_serial_d  = 1'b0;
        flipa_d           = 1'b0;
        conta_coluna_d    = 1'b0;
        conta_linha_d     = 1'b0;
        zera_coluna_d     = 1'b0;
        zera_linha_d      = 1'b0;
        fim_transmissao_d = 1'b0;
        erro_d            = 1'b0;
        ocupado_d         = (estado_d != INICIAL);
        case (estado_d)
            PREPARA: begin
                zera_linha_d  = 1'b1;
                zera_coluna_d = 1'b1;
                flipa_d       = shift_serial;
            end
            ENVIA_ALTO, ENVIA_BAIXO:  partida_serial_d = 1'b1;
            TROCA_BYTE, TROCA_VOLTA:  flipa_d = 1'b1;
            CONTA_COLUNA:             conta_coluna_d = 1'b1;
            CONTA_LINHA: begin
                conta_linha_d = 1'b1;
                zera_coluna_d = 1'b1;
            end
            FINAL:                    fim_transmissao_d = 1'b1;
`ifdef TRANSMISSAO_SERIAL_TIMEOUT_EN
            ERRO: begin
                erro_d    = 1'b1;
                ocupado_d = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q          <= INICIAL;
            partida_serial_q  <= 1'b0;
            flipa_q           <= 1'b0;
            conta_coluna_q    <= 1'b0;
            conta_linha_q     <= 1'b0;
            zera_coluna_q     <= 1'b0;
            zera_linha_q      <= 1'b0;
            ocupado_q         <= 1'b0;
            fim_transmissao_q <= 1'b0;
            erro_q            <= 1'b0;
`ifdef TRANSMISSAO_SERIAL_TIMEOUT_EN
            timeout_q         <= '0;
`endif
        end else begin
            estado_q          <= estado_d;
            partida_serial_q  <= partida_serial_d;
            flipa_q           <= flipa_d;
            conta_coluna_q    <= conta_coluna_d;
            conta_linha_q     <= conta_linha_d;
            zera_coluna_q     <= zera_coluna_d;
            zera_linha_q      <= zera_linha_d;
            ocupado_q         <= ocupado_d;
            fim_transmissao_q <= fim_transmissao_d;
            erro_q            <= erro_d;
`ifdef TRANSMISSAO_SERIAL_TIMEOUT_EN
            timeout_q         <= timeout_d;
`endif
        end
    end

    assign partida_serial  = partida_serial_q;
    assign flipa           = flipa_q;
    assign conta_coluna    = conta_coluna_q;
    assign conta_linha     = conta_linha_q;
    assign zera_coluna     = zera_coluna_q;
    assign zera_linha      = zera_linha_q;
    assign ocupado         = ocupado_q;
    assign fim_transmissao = fim_transmissao_q;
    assign erro            = erro_q;
    assign db_estado       = estado_q;

endmodule

// File: tb/tb_transmissao_serial_uc.sv
// Bench for transmissao_serial_uc: models the row/column counters, the byte-select flip-flop
// and a UART that answers pronto 10 cycles after each partida.
module tb_transmissao_serial_uc;

    localparam int DWELL     = 10;
    localparam int FRAME_CYC = 1 + 9 * (7 + DWELL + DWELL) + 1;

    typedef struct packed {
        logic       s;
        logic [1:0] r;
        logic [1:0] c;
    } byte_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       transmitir = 1'b0;
    logic       pronto;
    logic       fim_coluna;
    logic       fim_linha;
    logic       shift_serial;
    logic       partida_serial;
    logic       flipa;
    logic       conta_coluna;
    logic       conta_linha;
    logic       zera_coluna;
    logic       zera_linha;
    logic       ocupado;
    logic       fim_transmissao;
    logic       erro;
    logic [3:0] db_estado;

    logic       shift_q  = 1'b0;
    logic [1:0] row_q    = 2'd0;
    logic [1:0] col_q    = 2'd0;
    int         uart_cnt = 0;
    logic       stray    = 1'b0;
    logic       suppress = 1'b0;
    logic       clr_cnt  = 1'b0;

    int n_part = 0, n_flip = 0, n_ccol = 0, n_clin = 0, n_fim = 0, n_erro = 0;
    byte_t obs_q[$];
    byte_t exp_q[$];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    transmissao_serial_uc #(.TIMEOUT_CICLOS(20), .W_TIMEOUT(16)) dut (
        .clock(clock), .reset(reset), .transmitir(transmitir), .pronto(pronto),
        .fim_coluna(fim_coluna), .fim_linha(fim_linha), .shift_serial(shift_serial),
        .partida_serial(partida_serial), .flipa(flipa), .conta_coluna(conta_coluna),
        .conta_linha(conta_linha), .zera_coluna(zera_coluna), .zera_linha(zera_linha),
        .ocupado(ocupado), .fim_transmissao(fim_transmissao), .erro(erro), .db_estado(db_estado)
    );

    assign shift_serial = shift_q;
    assign fim_coluna   = (col_q == 2'd2);
    assign fim_linha    = (row_q == 2'd2);
    assign pronto       = stray | ((uart_cnt == 1) && !suppress);

    // Datapath and UART model; the datapath is not cleared by the FSM reset.
    always @(posedge clock) begin
        if (flipa) shift_q <= ~shift_q;
        if (zera_coluna) col_q <= 2'd0;
        else if (conta_coluna) col_q <= col_q + 2'd1;
        if (zera_linha) row_q <= 2'd0;
        else if (conta_linha) row_q <= row_q + 2'd1;
        if (partida_serial) uart_cnt <= DWELL;
        else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end

    // Event monitor: records every byte launch with the address and byte select it used.
    always @(negedge clock) begin
        if (clr_cnt) begin
            n_part = 0; n_flip = 0; n_ccol = 0; n_clin = 0; n_fim = 0; n_erro = 0;
            obs_q.delete();
        end else begin
            if (partida_serial) begin
                n_part++;
                obs_q.push_back({shift_q, row_q, col_q});
            end
            if (flipa)           n_flip++;
            if (conta_coluna)    n_ccol++;
            if (conta_linha)     n_clin++;
            if (fim_transmissao) n_fim++;
            if (erro)            n_erro++;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_counts();
        clr_cnt = 1'b1;
        @(negedge clock);
        #1;
        clr_cnt = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_frame();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                exp_q.push_back({1'b0, 2'(r), 2'(c)});
                exp_q.push_back({1'b1, 2'(r), 2'(c)});
            end
        end
    endtask

    task automatic wait_fim(input int limit, output int edges);
        edges = 0;
        do begin
            step();
            edges++;
        end while (fim_transmissao !== 1'b1 && edges < limit);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        transmitir = 1'b0;
        step();
        step();
        total++;
        if ({partida_serial, flipa, conta_coluna, conta_linha, zera_coluna, zera_linha,
             ocupado, fim_transmissao, erro} !== 9'b0) begin
            bad++;
            $display("FAIL reset_outputs: got %b want 000000000", {partida_serial, flipa,
                     conta_coluna, conta_linha, zera_coluna, zera_linha, ocupado, fim_transmissao, erro});
        end
        total++;
        if (db_estado !== 4'h0) begin
            bad++; $display("FAIL reset_state: got %0h want 0", db_estado);
        end
        reset = 1'b0;
        step();
        step();
        total++;
        if (db_estado !== 4'h0 || ocupado !== 1'b0) begin
            bad++; $display("FAIL idle_state: got %0h/%b want 0/0", db_estado, ocupado);
        end
    endtask

    task automatic test_frame();
        int e;
        int i;
        clear_counts();
        push_frame();
        transmitir = 1'b1;
        step();
        transmitir = 1'b0;
        total++;
        if (db_estado !== 4'h1 || zera_linha !== 1'b1 || zera_coluna !== 1'b1 || flipa !== 1'b0) begin
            bad++; $display("FAIL prepara: got st=%0h zl=%b zc=%b fl=%b want 1/1/1/0",
                            db_estado, zera_linha, zera_coluna, flipa);
        end
        wait_fim(400, e);
        total++;
        if (e !== FRAME_CYC - 2) begin bad++; $display("FAIL frame_time: got %0d want %0d", e, FRAME_CYC - 2); end
        step();
        total++;
        if (db_estado !== 4'h0 || ocupado !== 1'b0) begin
            bad++; $display("FAIL back_idle: got %0h/%b want 0/0", db_estado, ocupado);
        end
        total++; if (n_part !== 18) begin bad++; $display("FAIL n_partida: got %0d want 18", n_part); end
        total++; if (n_flip !== 18) begin bad++; $display("FAIL n_flipa: got %0d want 18", n_flip); end
        total++; if (n_ccol !== 6)  begin bad++; $display("FAIL n_conta_coluna: got %0d want 6", n_ccol); end
        total++; if (n_clin !== 2)  begin bad++; $display("FAIL n_conta_linha: got %0d want 2", n_clin); end
        total++; if (n_fim !== 1)   begin bad++; $display("FAIL n_fim: got %0d want 1", n_fim); end
        total++; if (n_erro !== 0)  begin bad++; $display("FAIL n_erro: got %0d want 0", n_erro); end
        total++; if (shift_q !== 1'b0) begin bad++; $display("FAIL shift_end: got %b want 0", shift_q); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("FAIL byte_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        i = 0;
        while (exp_q.size() > 0 && i < obs_q.size()) begin
            byte_t x = exp_q.pop_front();
            total++;
            if (obs_q[i] !== x) begin
                bad++; $display("FAIL order_%0d: got s%b(%0d,%0d) want s%b(%0d,%0d)", i,
                                obs_q[i].s, obs_q[i].r, obs_q[i].c, x.s, x.r, x.c);
            end
            i++;
        end
    endtask

    task automatic test_reset_mid();
        int e;
        int k;
        int i;
        clear_counts();
        transmitir = 1'b1;
        step();
        transmitir = 1'b0;
        k = 0;
        while (!(db_estado == 4'h7 && n_part == 8) && k < 300) begin step(); k++; end
        total++;
        if (k >= 300) begin bad++; $display("FAIL reach_espera_baixo: got timeout want state 7"); end
        reset = 1'b1;
        step();
        total++;
        if (db_estado !== 4'h0 || {partida_serial, flipa, conta_coluna, conta_linha, zera_coluna,
            zera_linha, ocupado, fim_transmissao, erro} !== 9'b0) begin
            bad++; $display("FAIL midreset: got st=%0h want 0 and outputs 0", db_estado);
        end
        total++;
        if (shift_q !== 1'b1) begin bad++; $display("FAIL midreset_shift: got %b want 1", shift_q); end
        reset = 1'b0;
        repeat (15) step();
        clear_counts();
        push_frame();
        transmitir = 1'b1;
        step();
        transmitir = 1'b0;
        total++;
        if (flipa !== 1'b1) begin bad++; $display("FAIL realign_flipa: got %b want 1", flipa); end
        wait_fim(400, e);
        total++;
        if (e !== FRAME_CYC - 2) begin bad++; $display("FAIL restart_time: got %0d want %0d", e, FRAME_CYC - 2); end
        step();
        total++; if (n_part !== 18) begin bad++; $display("FAIL restart_partida: got %0d want 18", n_part); end
        total++; if (n_flip !== 19) begin bad++; $display("FAIL restart_flipa: got %0d want 19", n_flip); end
        total++; if (n_fim !== 1)   begin bad++; $display("FAIL restart_fim: got %0d want 1", n_fim); end
        total++;
        if (obs_q.size() != exp_q.size()) begin
            bad++; $display("FAIL restart_bytes: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        i = 0;
        while (exp_q.size() > 0 && i < obs_q.size()) begin
            byte_t x = exp_q.pop_front();
            total++;
            if (obs_q[i] !== x) begin
                bad++; $display("FAIL restart_order_%0d: got s%b(%0d,%0d) want s%b(%0d,%0d)", i,
                                obs_q[i].s, obs_q[i].r, obs_q[i].c, x.s, x.r, x.c);
            end
            i++;
        end
    endtask

    task automatic test_noise();
        int e;
        int i;
        clear_counts();
        push_frame();
        transmitir = 1'b1;
        step();
        e = 0;
        do begin
            stray = (db_estado == 4'h2 || db_estado == 4'h3 || db_estado == 4'h6 || db_estado == 4'h9)
                    ? 1'($urandom_range(0, 1)) : 1'b0;
            transmitir = 1'($urandom_range(0, 1));
            step();
            e++;
        end while (fim_transmissao !== 1'b1 && e < 400);
        stray = 1'b0;
        transmitir = 1'b0;
        total++;
        if (e !== FRAME_CYC - 2) begin bad++; $display("FAIL noise_time: got %0d want %0d", e, FRAME_CYC - 2); end
        step();
        step();
        total++;
        if (db_estado !== 4'h0) begin bad++; $display("FAIL noise_idle: got %0h want 0", db_estado); end
        total++; if (n_part !== 18) begin bad++; $display("FAIL noise_partida: got %0d want 18", n_part); end
        total++; if (n_ccol !== 6)  begin bad++; $display("FAIL noise_coluna: got %0d want 6", n_ccol); end
        total++; if (n_clin !== 2)  begin bad++; $display("FAIL noise_linha: got %0d want 2", n_clin); end
        total++; if (n_fim !== 1)   begin bad++; $display("FAIL noise_fim: got %0d want 1", n_fim); end
        i = 0;
        while (exp_q.size() > 0 && i < obs_q.size()) begin
            byte_t x = exp_q.pop_front();
            total++;
            if (obs_q[i] !== x) begin
                bad++; $display("FAIL noise_order_%0d: got s%b(%0d,%0d) want s%b(%0d,%0d)", i,
                                obs_q[i].s, obs_q[i].r, obs_q[i].c, x.s, x.r, x.c);
            end
            i++;
        end
    endtask

    task automatic test_back_to_back();
        int e;
        int i;
        clear_counts();
        push_frame();
        push_frame();
        transmitir = 1'b1;
        step();
        wait_fim(400, e);
        total++;
        if (e !== FRAME_CYC - 2) begin bad++; $display("FAIL b2b_first: got %0d want %0d", e, FRAME_CYC - 2); end
        step();
        total++;
        if (db_estado !== 4'h0 || ocupado !== 1'b0) begin
            bad++; $display("FAIL b2b_gap: got %0h/%b want 0/0", db_estado, ocupado);
        end
        step();
        total++;
        if (db_estado !== 4'h1) begin bad++; $display("FAIL b2b_restart: got %0h want 1", db_estado); end
        wait_fim(400, e);
        total++;
        if (e !== FRAME_CYC - 2) begin bad++; $display("FAIL b2b_second: got %0d want %0d", e, FRAME_CYC - 2); end
        transmitir = 1'b0;
        step();
        step();
        total++;
        if (db_estado !== 4'h0) begin bad++; $display("FAIL b2b_stop: got %0h want 0", db_estado); end
        total++; if (n_part !== 36) begin bad++; $display("FAIL b2b_partida: got %0d want 36", n_part); end
        total++; if (n_flip !== 36) begin bad++; $display("FAIL b2b_flipa: got %0d want 36", n_flip); end
        total++; if (n_ccol !== 12) begin bad++; $display("FAIL b2b_coluna: got %0d want 12", n_ccol); end
        total++; if (n_clin !== 4)  begin bad++; $display("FAIL b2b_linha: got %0d want 4", n_clin); end
        total++; if (n_fim !== 2)   begin bad++; $display("FAIL b2b_fim: got %0d want 2", n_fim); end
        i = 0;
        while (exp_q.size() > 0 && i < obs_q.size()) begin
            byte_t x = exp_q.pop_front();
            total++;
            if (obs_q[i] !== x) begin
                bad++; $display("FAIL b2b_order_%0d: got s%b(%0d,%0d) want s%b(%0d,%0d)", i,
                                obs_q[i].s, obs_q[i].r, obs_q[i].c, x.s, x.r, x.c);
            end
            i++;
        end
    endtask

`ifdef TRANSMISSAO_SERIAL_TIMEOUT_EN
    task automatic test_timeout();
        int e;
        int k;
        int i;
        clear_counts();
        exp_q.push_back({1'b0, 2'd0, 2'd0});
        exp_q.push_back({1'b1, 2'd0, 2'd0});
        exp_q.push_back({1'b0, 2'd0, 2'd1});
        exp_q.push_back({1'b1, 2'd0, 2'd1});
        transmitir = 1'b1;
        step();
        transmitir = 1'b0;
        k = 0;
        while (!(db_estado == 4'h7 && n_part == 4) && k < 300) begin step(); k++; end
        suppress = 1'b1;
        k = 0;
        do begin step(); k++; end while (erro !== 1'b1 && k < 100);
        total++;
        if (k !== 20) begin bad++; $display("FAIL timeout_time: got %0d want 20", k); end
        total++;
        if (ocupado !== 1'b0 || db_estado !== 4'hE) begin
            bad++; $display("FAIL timeout_state: got %0h/%b want e/0", db_estado, ocupado);
        end
        suppress = 1'b0;
        push_frame();
        transmitir = 1'b1;
        step();
        transmitir = 1'b0;
        wait_fim(400, e);
        total++;
        if (e !== FRAME_CYC - 2) begin bad++; $display("FAIL timeout_restart: got %0d want %0d", e, FRAME_CYC - 2); end
        step();
        total++; if (n_part !== 22) begin bad++; $display("FAIL timeout_partida: got %0d want 22", n_part); end
        i = 0;
        while (exp_q.size() > 0 && i < obs_q.size()) begin
            byte_t x = exp_q.pop_front();
            total++;
            if (obs_q[i] !== x) begin
                bad++; $display("FAIL timeout_order_%0d: got s%b(%0d,%0d) want s%b(%0d,%0d)", i,
                                obs_q[i].s, obs_q[i].r, obs_q[i].c, x.s, x.r, x.c);
            end
            i++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_frame();
        test_reset_mid();
        test_noise();
        test_back_to_back();
`ifdef TRANSMISSAO_SERIAL_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
